// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: deframer state encoding,
// oversampling ratio and the baud tick divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_e;

    localparam int OVERSAMPLE = 16;

    // Rounded clocks per oversample tick, never below one.
    function automatic int baud_div(input int clk, input int baud);
        int div;
        div = (clk + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
        if (div < 1) begin
            return 1;
        end else begin
            return div;
        end
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign empty_o   = (count_q == {(PTR_W + 1){1'b0}});
    assign full_o    = (count_q == FULL_CNT);
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign rdata_o   = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head never shows stale bytes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: synchronises rx_i, deframes characters with a 16x
// oversampling FSM and buffers them in a show-ahead byte FIFO with sticky errors.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 40_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       read_i,
    output logic       rvalid_o,
    output logic [7:0] rdata_o,
    output logic       frame_err_o,
    output logic       overflow_o,
    input  logic       err_clr_i
);
    localparam int DIV   = baud_div(CLK_FREQ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       MID_PHASE = 4'((OVERSAMPLE / 2) - 1);

    uart_rx_state_e   state_q, state_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       phase_q, phase_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;
    logic             tick_s, mid_s, fall_s;
    logic             push_s, frame_set_s, shift_en_s;
    logic             fifo_full_s, fifo_empty_s, pop_s;

    assign tick_s = (div_q == DIV_LAST);
    assign mid_s  = tick_s & (phase_q == MID_PHASE);
    assign fall_s = rx_prev_q & ~rx_sync_q;
    assign pop_s  = read_i & ~fifo_empty_s;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fall_s) state_d = START;
                else        state_d = IDLE;
            end
            START: begin
                if (mid_s) state_d = rx_sync_q ? IDLE : DATA;
                else       state_d = START;
            end
            DATA: begin
                if (mid_s && (bit_cnt_q == 3'd7)) state_d = STOP;
                else                              state_d = DATA;
            end
            STOP: begin
                if (mid_s) state_d = rx_sync_q ? IDLE : BREAK;
                else       state_d = STOP;
            end
            BREAK: begin
                if (rx_sync_q) state_d = IDLE;
                else           state_d = BREAK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_s      = 1'b0;
        frame_set_s = 1'b0;
        shift_en_s  = 1'b0;
        case (state_q)
            DATA: shift_en_s = mid_s;
            STOP: begin
                push_s      = mid_s & rx_sync_q;
                frame_set_s = mid_s & ~rx_sync_q;
            end
            default: begin
                push_s      = 1'b0;
                frame_set_s = 1'b0;
                shift_en_s  = 1'b0;
            end
        endcase
    end

    // Divider and phase are held at zero while idle so each frame starts aligned.
    always_comb begin
        div_d     = div_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (state_q == IDLE) begin
            div_d     = {DIV_W{1'b0}};
            phase_d   = 4'd0;
            bit_cnt_d = 3'd0;
        end else if (tick_s) begin
            div_d   = {DIV_W{1'b0}};
            phase_d = phase_q + 4'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        if (shift_en_s) begin
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
            shift_d = shift_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q     <= {DIV_W{1'b0}};
            phase_q   <= 4'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            div_q     <= div_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // A set event in the same cycle as err_clr_i keeps the flag high.
    always_comb begin
        frame_err_d = frame_set_s | (frame_err_q & ~err_clr_i);
        overflow_d  = (push_s & fifo_full_s & ~pop_s) | (overflow_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .wdata_i (shift_q),
        .pop_i   (pop_s),
        .rdata_o (rdata_o),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign rvalid_o    = ~fifo_empty_s;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames are driven at 16 clocks/bit,
// a queue-based reference FIFO predicts contents and flags, a monitor checks pops.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_i;
    logic       rx_i;
    logic       read_i;
    logic       rvalid_o;
    logic [7:0] rdata_o;
    logic       frame_err_o;
    logic       overflow_o;
    logic       err_clr_i;

    int         checks;
    int         errors;
    int         cyc;
    int         exp_rise_cyc;
    logic [7:0] mdl_q[$];
    bit         m_ferr;
    bit         m_ovf;

    localparam int MDL_DEPTH = 8;

    uart_rx_fifo #(
        .CLK_FREQ   (1_843_200),
        .BAUD       (115_200),
        .FIFO_DEPTH (MDL_DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .read_i      (read_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .err_clr_i   (err_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the reference queue whenever the DUT honours a read, and
    // times the first appearance of a byte in an empty FIFO.
    initial begin
        bit rv_prev;
        logic [7:0] exp_b;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (read_i && rvalid_o) begin
                chk("pop_model_nonempty", {31'd0, mdl_q.size() != 0}, 32'd1);
                if (mdl_q.size() != 0) begin
                    exp_b = mdl_q.pop_front();
                    chk("pop_data", {24'd0, rdata_o}, {24'd0, exp_b});
                end
            end
            if (rvalid_o && !rv_prev && exp_rise_cyc != 0) begin
                chk("push_latency", cyc, exp_rise_cyc);
                exp_rise_cyc = 0;
            end
            rv_prev = rvalid_o;
        end
    end

    task automatic check_status(input string tag);
        chk({tag, "_rvalid"}, {31'd0, rvalid_o}, {31'd0, mdl_q.size() != 0});
        if (mdl_q.size() != 0) chk({tag, "_rdata"}, {24'd0, rdata_o}, {24'd0, mdl_q[0]});
        chk({tag, "_frame_err"}, {31'd0, frame_err_o}, {31'd0, m_ferr});
        chk({tag, "_overflow"}, {31'd0, overflow_o}, {31'd0, m_ovf});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        rx_i  = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        mdl_q.delete();
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        exp_rise_cyc = 0;
    endtask

    task automatic do_read();
        @(negedge clk);
        read_i = 1'b1;
        @(negedge clk);
        read_i = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Drives one 8N1 frame. stop_ok=0 holds the line low for low_hold clocks
    // from the stop bit on; rd_at_push reads on the stop-sample cycle;
    // abort_bit >= 0 resets the DUT inside that bit.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_hold,
                              input bit rd_at_push, input int abort_bit);
        logic [9:0] bits;
        int         c0;
        bit         aborted;
        bits    = {stop_ok, b, 1'b0};
        aborted = 1'b0;
        @(negedge clk);
        c0 = cyc;
        if (stop_ok && mdl_q.size() == 0 && abort_bit < 0) exp_rise_cyc = c0 + 155;
        for (int j = 0; j < 10 && !aborted; j++) begin
            for (int k = 0; k < 16 && !aborted; k++) begin
                rx_i = bits[j];
                if (rd_at_push && j == 9 && k == 10) read_i = 1'b1;
                if (rd_at_push && j == 9 && k == 11) read_i = 1'b0;
                if (abort_bit == j && k == 4) begin
                    rx_i  = 1'b1;
                    rst_i = 1'b1;
                    repeat (2) @(negedge clk);
                    rst_i = 1'b0;
                    mdl_q.delete();
                    m_ferr = 1'b0;
                    m_ovf  = 1'b0;
                    exp_rise_cyc = 0;
                    aborted = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        if (!aborted) begin
            if (!stop_ok) begin
                repeat (low_hold - 16) @(negedge clk);
                m_ferr = 1'b1;
            end else if (mdl_q.size() < MDL_DEPTH) begin
                mdl_q.push_back(b);
            end else begin
                m_ovf = 1'b1;
            end
        end
        rx_i = 1'b1;
        repeat (8) @(negedge clk);
        if (stop_ok && !aborted) chk("push_seen", exp_rise_cyc, 0);
        exp_rise_cyc = 0;
    endtask

    initial begin
        logic [7:0] rb;
        int         n;
        checks = 0;
        errors = 0;
        cyc    = 0;
        exp_rise_cyc = 0;
        rst_i     = 1'b1;
        rx_i      = 1'b1;
        read_i    = 1'b0;
        err_clr_i = 1'b0;
        do_reset();
        chk("reset_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("reset_rdata", {24'd0, rdata_o}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err_o}, 32'd0);
        chk("reset_overflow", {31'd0, overflow_o}, 32'd0);

        send_frame(8'hA5, 1'b1, 0, 1'b0, -1);
        check_status("a5");
        do_read();
        check_status("a5_read");

        @(negedge clk);
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        rx_i = 1'b1;
        repeat (200) @(negedge clk);
        check_status("glitch");

        send_frame(8'h3C, 1'b0, 40, 1'b0, -1);
        check_status("frame_err");
        send_frame(8'h81, 1'b1, 0, 1'b0, -1);
        check_status("after_break");
        do_read();
        do_clear();
        check_status("err_clr");

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 0, 1'b0, -1);
        check_status("overflow");
        for (int i = 0; i < 8; i++) begin
            do_read();
            check_status("drain");
        end
        do_read();
        check_status("read_empty");
        do_clear();

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                rb = 8'($urandom);
                send_frame(rb, 1'b1, 0, 1'b0, -1);
            end
            check_status("rand_fill");
            n = $urandom_range(0, mdl_q.size() + 1);
            for (int i = 0; i < n; i++) do_read();
            check_status("rand_drain");
        end
        while (mdl_q.size() != 0) do_read();
        do_clear();
        check_status("rand_end");

        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 0, 1'b0, -1);
        send_frame(8'h55, 1'b1, 0, 1'b1, -1);
        check_status("full_push_pop");
        chk("full_push_pop_tail", {24'd0, mdl_q[mdl_q.size() - 1]}, 32'h55);

        send_frame(8'h77, 1'b1, 0, 1'b0, 4);
        repeat (20) @(negedge clk);
        chk("midreset_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("midreset_rdata", {24'd0, rdata_o}, 32'd0);
        check_status("midreset");
        send_frame(8'h42, 1'b1, 0, 1'b0, -1);
        check_status("after_reset");
        do_read();
        check_status("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
